regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Writeback arbiter that sits in front of the 32x32 register file's write port and drives its RegWrite/z_write/z_data inputs. It accepts results from two producers, the ALU and the memory/load unit, over valid/ready handshakes, and buffers them in per-source FIFOs. A round-robin arbiter retires at most one write per clock.

## Interface
- DEPTH, 2, entries per source FIFO; power of two, ≥2
- DROP_R0, 1, when 1 a write to address 0 is consumed but never asserted on RegWrite
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU FIFO can accept
- alu_dest  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  load result valid
- mem_ready  out  1  load FIFO can accept
- mem_dest  in  5  load destination register
- mem_data  in  32  load result
- RegWrite  out  1  register-file write enable
- z_write  out  5  register-file write address
- z_data  out  32  register-file write data
- idle  out  1  both FIFOs empty and RegWrite low

## Operation
- Handshake: an entry is accepted on a rising edge when valid && ready. Each source's ready = !full of its own FIFO.
  - ready is computed from the registered count only. A full FIFO does not accept, even in a cycle where it pops.
  - While valid is high and ready is low, the producer holds dest/data stable.
- FIFO: ordering within one source is strictly in-order. No ordering is guaranteed between sources; producers must not have two outstanding writes to the same register across sources.
- Arbiter states: GRANT_ALU_PRI and GRANT_MEM_PRI, which hold the priority pointer.
  - If only one FIFO is non-empty, pop it.
  - If both are non-empty, pop the prioritized one and move priority to the other.
  - If neither is non-empty, no pop and the pointer is unchanged.
- Output stage: a registered output loads the popped entry's dest/data every cycle a pop occurs. RegWrite = 1 unless DROP_R0 && dest == 0.
  - In a cycle with no pop, RegWrite = 0. z_write/z_data hold their last values.
- idle = both FIFOs empty && !RegWrite (combinational from registers).
- Reset (async assert, mid-operation included): both FIFOs are flushed and their contents discarded. The pointer goes to GRANT_ALU_PRI. RegWrite=0, z_write=0, z_data=0, alu_ready=1, mem_ready=1, idle=1.
- Pointer arithmetic: DEPTH-wrap pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits. Wrap-around from DEPTH-1 to 0 is natural.

## Timing
- Input accepted at edge N. The entry is poppable during cycle N→N+1, so with no contention the output registers load at edge N+1.
- RegWrite is high for exactly one cycle per retired entry (N+1→N+2). The register file captures at edge N+2.
- Minimum latency is therefore 1 cycle to RegWrite and 2 cycles to register-file visibility. Each cycle of contention adds one cycle.
- Throughput is one write per cycle in aggregate. Each source sustains one per cycle when uncontended; each sustains one per two cycles when both are continuously busy.
- Simultaneous push and pop on a non-full FIFO: the count is unchanged and both operations take effect.
- Push into an empty FIFO: the entry is not visible to the arbiter in the same cycle (no bypass).
- Reset deassertion is synchronized externally. The first accept can occur at the first rising edge after reset_n rises.

## Structure
- A shared package holds:
  - REG_ADDR_W=5
  - REG_DATA_W=32
  - the wb_entry_t typedef (dest, data)
  - the arbiter-state enum (GRANT_ALU_PRI, GRANT_MEM_PRI)
- Sub-module wb_fifo, parameterized by DEPTH and carrying wb_entry_t, with ports push/pop/full/empty/head. It is instantiated twice.
- The arbiter and output register are inline in regfile_writeback.

## Test plan
- Reset state: with reset_n low, check RegWrite=0, z_write=0, z_data=0, both readies=1, idle=1. Assert reset_n low mid-burst with 2 entries queued, then release: both FIFOs are empty and no RegWrite pulse follows.
- Single ALU write: alu dest=5, data=32'hDEADBEEF accepted at edge N. At edge N+1, RegWrite=1, z_write=5, z_data=32'hDEADBEEF for one cycle. idle returns to 1 at N+2.
- Contention: alu (3, 32'h11) and mem (4, 32'h22) accepted on the same edge, from reset. Expect the ALU write first (z_write=3), then z_write=4 the next cycle. On the next simultaneous pair the mem entry goes first.
- Backpressure: with DEPTH=2, push 3 ALU entries back-to-back while mem also streams continuously.
  - alu_ready drops to 0 once the FIFO is full.
  - All 3 ALU values retire in order (10, 20, 30) with no loss or duplication.
- R0 drop: with DROP_R0=1, a mem write (0, 32'hFFFF) is accepted and popped, but RegWrite stays 0 that cycle. A following (1, 32'h1) retires normally one cycle later.
- Full-rate stream: 8 consecutive ALU writes with mem idle. RegWrite stays high for 8 consecutive cycles, the FIFO pointers wrap, and z_write follows the sequence 1..8.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// Shared types for the register-file writeback path: entry layout,
// arbiter priority states and the write-enable rule for register 0.
package regfile_writeback_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        GRANT_ALU_PRI = 1'b0,
        GRANT_MEM_PRI = 1'b1
    } arb_state_t;

    // Register 0 is hardwired in the register file, so its writes may be
    // consumed silently instead of being asserted on the write port.
    function automatic logic write_enabled(input logic [REG_ADDR_W-1:0] dest,
                                           input bit drop_r0);
        return !(drop_r0 && (dest == '0));
    endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Per-source result FIFO: power-of-two depth, wrapping pointers plus an
// occupancy count. The head is only visible once written (no bypass).
module wb_fifo
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the registered count, so a full FIFO refuses a push
    // even in a cycle where it is also popping.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = storage[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; flushing the pointers discards its contents.
    always_ff @(posedge clock) begin
        if (do_push) begin
            storage[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter: buffers ALU and load results and retires at most one
// register-file write per clock under round-robin priority.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter bit DROP_R0 = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_dest,
    input  logic [REG_DATA_W-1:0] alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic [REG_DATA_W-1:0] mem_data,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] z_write,
    output logic [REG_DATA_W-1:0] z_data,
    output logic                  idle
);

    arb_state_t state;
    arb_state_t next_state;
    wb_entry_t  alu_in;
    wb_entry_t  mem_in;
    wb_entry_t  alu_head;
    wb_entry_t  mem_head;
    wb_entry_t  popped;
    logic       alu_full;
    logic       alu_empty;
    logic       mem_full;
    logic       mem_empty;
    logic       alu_push;
    logic       mem_push;
    logic       alu_pop;
    logic       mem_pop;

    assign alu_ready = !alu_full;
    assign mem_ready = !mem_full;
    assign alu_push  = alu_valid && alu_ready;
    assign mem_push  = mem_valid && mem_ready;
    assign alu_in    = '{dest: alu_dest, data: alu_data};
    assign mem_in    = '{dest: mem_dest, data: mem_data};

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (alu_push),
        .push_entry (alu_in),
        .pop        (alu_pop),
        .full       (alu_full),
        .empty      (alu_empty),
        .head       (alu_head)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (mem_push),
        .push_entry (mem_in),
        .pop        (mem_pop),
        .full       (mem_full),
        .empty      (mem_empty),
        .head       (mem_head)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= GRANT_ALU_PRI;
        end else begin
            state <= next_state;
        end
    end

    // Priority only rotates when both sources compete; a lone source is
    // served without disturbing the pointer.
    always_comb begin
        alu_pop    = 1'b0;
        mem_pop    = 1'b0;
        next_state = state;
        popped     = alu_head;
        if (!alu_empty && !mem_empty) begin
            if (state == GRANT_ALU_PRI) begin
                alu_pop    = 1'b1;
                next_state = GRANT_MEM_PRI;
            end else begin
                mem_pop    = 1'b1;
                popped     = mem_head;
                next_state = GRANT_ALU_PRI;
            end
        end else if (!alu_empty) begin
            alu_pop = 1'b1;
        end else if (!mem_empty) begin
            mem_pop = 1'b1;
            popped  = mem_head;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite <= 1'b0;
            z_write  <= '0;
            z_data   <= '0;
        end else if (alu_pop || mem_pop) begin
            RegWrite <= write_enabled(popped.dest, DROP_R0);
            z_write  <= popped.dest;
            z_data   <= popped.data;
        end else begin
            RegWrite <= 1'b0;
        end
    end

    assign idle = alu_empty && mem_empty && !RegWrite;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, single write, contention,
// backpressure, register-0 drop, full-rate streaming and mid-burst reset.
module tb_regfile_writeback;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_dest = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_dest = '0;
    logic [31:0] mem_data = '0;
    logic        RegWrite;
    logic [4:0]  z_write;
    logic [31:0] z_data;
    logic        idle;

    int vectors = 0;
    int miscompares = 0;

    // Expected retire data and alu_ready for each edge of the backpressure run.
    logic [31:0] bpData [8] = '{32'd0, 32'd10, 32'd100, 32'd20, 32'd101, 32'd30, 32'd102, 32'd103};
    logic        bpWe   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        bpRdy  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    regfile_writeback #(.DEPTH(2), .DROP_R0(1'b1)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_dest  (alu_dest),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_dest  (mem_dest),
        .mem_data  (mem_data),
        .RegWrite  (RegWrite),
        .z_write   (z_write),
        .z_data    (z_data),
        .idle      (idle)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                                 input logic mv, input logic [4:0] md, input logic [31:0] mdat);
        alu_valid = av;
        alu_dest  = ad;
        alu_data  = adat;
        mem_valid = mv;
        mem_dest  = md;
        mem_data  = mdat;
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        reset_n = 1'b0;
        #2;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic checkIdleState(input string tag);
        checkOutput({tag, ".RegWrite"}, 32'(RegWrite), 32'd0);
        checkOutput({tag, ".idle"}, 32'(idle), 32'd1);
        checkOutput({tag, ".alu_ready"}, 32'(alu_ready), 32'd1);
        checkOutput({tag, ".mem_ready"}, 32'(mem_ready), 32'd1);
    endtask

    initial begin
        int aIdx;
        int mIdx;
        logic aAcc;
        logic mAcc;

        $display("[TB] start");

        // Reset state
        #1;
        reset_n = 1'b0;
        #2;
        checkIdleState("reset");
        checkOutput("reset.z_write", 32'(z_write), 32'd0);
        checkOutput("reset.z_data", z_data, 32'd0);
        tick();
        reset_n = 1'b1;

        // Single ALU write
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("single.N.RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("single.N.idle", 32'(idle), 32'd0);
        tick();
        checkOutput("single.N1.RegWrite", 32'(RegWrite), 32'd1);
        checkOutput("single.N1.z_write", 32'(z_write), 32'd5);
        checkOutput("single.N1.z_data", z_data, 32'hDEADBEEF);
        tick();
        checkOutput("single.N2.RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("single.N2.idle", 32'(idle), 32'd1);
        checkOutput("single.N2.z_write_hold", 32'(z_write), 32'd5);

        // Contention from reset: ALU first, then priority flips to mem
        applyReset();
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checkOutput("cont1.first.z_write", 32'(z_write), 32'd3);
        checkOutput("cont1.first.z_data", z_data, 32'h11);
        checkOutput("cont1.first.RegWrite", 32'(RegWrite), 32'd1);
        tick();
        checkOutput("cont1.second.z_write", 32'(z_write), 32'd4);
        checkOutput("cont1.second.z_data", z_data, 32'h22);
        checkOutput("cont1.second.RegWrite", 32'(RegWrite), 32'd1);
        tick();
        checkOutput("cont1.done.idle", 32'(idle), 32'd1);
        applyStimulus(1'b1, 5'd6, 32'h33, 1'b1, 5'd7, 32'h44);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checkOutput("cont2.first.z_write", 32'(z_write), 32'd7);
        checkOutput("cont2.first.z_data", z_data, 32'h44);
        tick();
        checkOutput("cont2.second.z_write", 32'(z_write), 32'd6);
        checkOutput("cont2.second.z_data", z_data, 32'h33);
        tick();
        checkOutput("cont2.done.RegWrite", 32'(RegWrite), 32'd0);

        // Backpressure: 3 ALU entries against a continuous mem stream
        applyReset();
        aIdx = 0;
        mIdx = 0;
        for (int s = 0; s < 8; s++) begin
            alu_valid = (aIdx < 3);
            alu_dest  = 5'(10 + aIdx);
            alu_data  = 32'((aIdx + 1) * 10);
            mem_valid = (s < 6);
            mem_dest  = 5'(20 + mIdx);
            mem_data  = 32'(100 + mIdx);
            aAcc = alu_valid && alu_ready;
            mAcc = mem_valid && mem_ready;
            tick();
            if (aAcc) aIdx++;
            if (mAcc) mIdx++;
            checkOutput($sformatf("bp.e%0d.RegWrite", s + 1), 32'(RegWrite), 32'(bpWe[s]));
            if (bpWe[s]) begin
                checkOutput($sformatf("bp.e%0d.z_data", s + 1), z_data, bpData[s]);
            end
            checkOutput($sformatf("bp.e%0d.alu_ready", s + 1), 32'(alu_ready), 32'(bpRdy[s]));
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        checkOutput("bp.drain.RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("bp.drain.idle", 32'(idle), 32'd1);
        checkOutput("bp.alu_accepted", 32'(aIdx), 32'd3);
        checkOutput("bp.mem_accepted", 32'(mIdx), 32'd4);

        // Register-0 write is consumed without asserting RegWrite
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("r0.drop.RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("r0.drop.z_data", z_data, 32'hFFFF);
        checkOutput("r0.drop.idle", 32'(idle), 32'd0);
        tick();
        checkOutput("r0.next.RegWrite", 32'(RegWrite), 32'd1);
        checkOutput("r0.next.z_write", 32'(z_write), 32'd1);
        checkOutput("r0.next.z_data", z_data, 32'h1);
        tick();
        checkOutput("r0.done.idle", 32'(idle), 32'd1);

        // Full-rate stream of 8 ALU writes, pointers wrap several times
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) applyStimulus(1'b1, 5'(k), 32'(32'hA0 + k), 1'b0, 5'd0, 32'd0);
            else        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            tick();
            if (k == 1) begin
                checkOutput("stream.e1.RegWrite", 32'(RegWrite), 32'd0);
            end else begin
                checkOutput($sformatf("stream.e%0d.RegWrite", k), 32'(RegWrite), 32'd1);
                checkOutput($sformatf("stream.e%0d.z_write", k), 32'(z_write), 32'(k - 1));
                checkOutput($sformatf("stream.e%0d.z_data", k), z_data, 32'(32'hA0 + k - 1));
            end
            checkOutput($sformatf("stream.e%0d.alu_ready", k), 32'(alu_ready), 32'd1);
        end
        tick();
        checkOutput("stream.end.RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("stream.end.idle", 32'(idle), 32'd1);

        // Reset mid-burst with two entries queued
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd12, 32'h1212);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("midrst.queued.idle", 32'(idle), 32'd0);
        reset_n = 1'b0;
        #2;
        checkIdleState("midrst.asserted");
        checkOutput("midrst.asserted.z_write", 32'(z_write), 32'd0);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkIdleState($sformatf("midrst.after%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
